// File: rtl/bitwise_op_arbiter_pkg.sv
// Shared types and the per-bit logic-op helper for bitwise_op_arbiter.
package bitwise_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_RSVD = 2'b11
    } bitwise_op_e;

    typedef struct packed {
        logic err;
        logic data;
    } bitwise_bit_t;

    // One result bit plus the reserved-opcode flag; callers loop over the operand width.
    function automatic bitwise_bit_t bitwise_apply(input bitwise_op_e op, input logic x, input logic y);
        bitwise_bit_t res;
        res = '0;
        case (op)
            OP_AND:  res.data = x & y;
            OP_OR:   res.data = x | y;
            OP_XOR:  res.data = x ^ y;
            default: res.err  = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bitwise_op_arbiter_if.sv
// Request/response bundle between logic-op clients (master) and the shared arbiter (slave).
interface bitwise_op_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 4
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*2-1:0]      req_op;
    logic [NUM_REQ*DATA_W-1:0] req_x;
    logic [NUM_REQ*DATA_W-1:0] req_y;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [DATA_W-1:0]         resp_data;
    logic [ID_W-1:0]           resp_id;
    logic                      resp_err;

    modport master (
        output req_valid, req_op, req_x, req_y, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_x, req_y, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, resp_err
    );

endinterface

// File: rtl/bitwise_op_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from last_grant+1, pointer moves only on advance.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] last_grant;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant   = '0;
        gnt_idx = last_grant;
        idx     = '0;
        found   = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IW'((32'(last_grant) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = idx;
                found      = 1'b1;
            end
        end
    end

    // Reset to N-1 so requester 0 is searched first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= IW'(N - 1);
        end else if (advance) begin
            last_grant <= gnt_idx;
        end
    end

endmodule

// File: rtl/bitwise_op_arbiter.sv
// Shared registered AND/OR/XOR unit arbitrated round-robin between NUM_REQ requesters.
// Optional stall counter port enabled by BITWISE_ARB_STALL_CNT_EN.
module bitwise_op_arbiter
    import bitwise_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 4
) (
    input  logic                clk,
    input  logic                rstn,
    bitwise_op_arbiter_if.slave bus
`ifdef BITWISE_ARB_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic               can_accept;
    logic               xfer;
    logic [ID_W-1:0]    gnt_id;
    bitwise_op_e        sel_op;
    logic [DATA_W-1:0]  sel_x;
    logic [DATA_W-1:0]  sel_y;
    logic [DATA_W-1:0]  calc_data;
    logic               calc_err;
    bitwise_bit_t       bit_res;

    logic               resp_valid_q;
    logic [DATA_W-1:0]  resp_data_q;
    logic [ID_W-1:0]    resp_id_q;
    logic               resp_err_q;

    // A full output slot that is draining this cycle can be refilled in the same cycle.
    assign can_accept    = !resp_valid_q || bus.resp_ready;
    assign bus.req_ready = grant & {NUM_REQ{can_accept}};
    assign xfer          = |bus.req_ready;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk     (clk),
        .rstn    (rstn),
        .req     (bus.req_valid),
        .advance (xfer),
        .grant   (grant)
    );

    // One-hot operand mux and the combinational op ahead of the output register.
    always_comb begin
        gnt_id    = '0;
        sel_op    = OP_AND;
        sel_x     = '0;
        sel_y     = '0;
        calc_data = '0;
        calc_err  = 1'b0;
        bit_res   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_id = ID_W'(i);
                sel_op = bitwise_op_e'(bus.req_op[OP_W*i +: OP_W]);
                sel_x  = bus.req_x[DATA_W*i +: DATA_W];
                sel_y  = bus.req_y[DATA_W*i +: DATA_W];
            end
        end
        for (int unsigned b = 0; b < DATA_W; b++) begin
            bit_res      = bitwise_apply(sel_op, sel_x[b], sel_y[b]);
            calc_data[b] = bit_res.data;
            calc_err     = bit_res.err;
        end
    end

    // Output register: payload holds on stall and on drain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_err_q   <= 1'b0;
        end else if (xfer) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= calc_data;
            resp_id_q    <= gnt_id;
            resp_err_q   <= calc_err;
        end else if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_err   = resp_err_q;

`ifdef BITWISE_ARB_STALL_CNT_EN
    // Cycles with pending requests but no accept, saturating.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if ((|bus.req_valid) && !xfer && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bitwise_op_arbiter.sv
// Self-checking bench for bitwise_op_arbiter: directed steps plus random traffic vs a behavioural model.
module tb_bitwise_op_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rstn;

    bitwise_op_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

`ifdef BITWISE_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    bitwise_op_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef BITWISE_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Requester-side stimulus state
    logic [N-1:0] v;
    logic [1:0]   op [N];
    logic [W-1:0] x  [N];
    logic [W-1:0] y  [N];
    logic         rr;

    // Behavioural model of the response slot and arbitration pointer
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_id;
    bit           m_err;
    int           m_last;
    int           m_stall;

    logic [W-1:0] tbl [N] = '{4'h8, 4'hE, 4'h6, 4'h0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_apply(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            2'd0:    return {1'b0, a & b};
            2'd1:    return {1'b0, a | b};
            2'd2:    return {1'b0, a ^ b};
            default: return {1'b1, {W{1'b0}}};
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_err   = 1'b0;
        m_last  = N - 1;
        m_stall = 0;
    endtask

    task automatic drive();
        bus.req_valid  = v;
        bus.resp_ready = rr;
        for (int i = 0; i < N; i++) begin
            bus.req_op[2*i +: 2] = op[i];
            bus.req_x[W*i +: W]  = x[i];
            bus.req_y[W*i +: W]  = y[i];
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'(m_valid));
        chk({tag, "_resp_data"},  32'(bus.resp_data),  32'(m_data));
        chk({tag, "_resp_id"},    32'(bus.resp_id),    32'(m_id));
        chk({tag, "_resp_err"},   32'(bus.resp_err),   32'(m_err));
`ifdef BITWISE_ARB_STALL_CNT_EN
        chk({tag, "_stall_cnt"},  32'(stall_cnt),      32'(m_stall));
`endif
    endtask

    // One clock: drive at negedge, check ready, update model at posedge, check outputs at next negedge.
    task automatic step(output int acc);
        int w;
        bit can;
        logic [N-1:0] e;
        drive();
        #1;
        can = !m_valid || rr;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            if (w < 0 && v[(m_last + k) % N]) w = (m_last + k) % N;
        end
        acc = (can && w >= 0) ? w : -1;
        e = '0;
        if (acc >= 0) e[acc] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(e));
        @(posedge clk);
        if (acc >= 0) begin
            {m_err, m_data} = ref_apply(op[acc], x[acc], y[acc]);
            m_valid = 1'b1;
            m_id    = acc;
            m_last  = acc;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        if ((|v) && acc < 0 && m_stall < 65535) m_stall++;
        @(negedge clk);
        chk_outputs("step");
    endtask

    task automatic reset_mid();
        #2 rstn = 1'b0;
        #1;
        model_reset();
        chk_outputs("async_rst");
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int acc;
        int id_before;
        rstn = 1'b0;
        v    = '0;
        rr   = 1'b0;
        for (int i = 0; i < N; i++) begin
            op[i] = '0;
            x[i]  = '0;
            y[i]  = '0;
        end
        drive();
        model_reset();
        repeat (2) @(negedge clk);
        chk_outputs("reset");
        rstn = 1'b1;

        // Idle after reset
        step(acc);
        step(acc);

        // Single XOR from requester 2
        v = 4'b0100; op[2] = 2'b10; x[2] = 4'b1100; y[2] = 4'b1010; rr = 1'b1;
        step(acc);
        chk("single_data", 32'(bus.resp_data), 32'h6);
        chk("single_id", 32'(bus.resp_id), 32'd2);
        v = '0;

        // Reset while a response is pending
        reset_mid();

        // Tie between 0 and 3 right after reset
        for (int i = 0; i < N; i++) begin
            op[i] = 2'(i); x[i] = 4'hC; y[i] = 4'hA;
        end
        v = 4'b1001;
        step(acc);
        chk("tie_id", 32'(bus.resp_id), 32'd0);

        // Full contention, one result per cycle
        v = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            step(acc);
            v = 4'b1111;
            chk("rr_id", 32'(bus.resp_id), 32'((1 + n) % N));
            chk("rr_data", 32'(bus.resp_data), 32'(tbl[(1 + n) % N]));
            chk("rr_err", 32'(bus.resp_err), 32'(((1 + n) % N) == 3));
        end

        // Back-pressure for 3 cycles, then release
        id_before = m_id;
        rr = 1'b0;
        repeat (3) step(acc);
        rr = 1'b1;
        step(acc);
        chk("bp_next_id", 32'(bus.resp_id), 32'((id_before + 1) % N));

        // Random traffic; requesters hold valid/operands until accepted
        for (int c = 0; c < 300; c++) begin
            rr = ($urandom_range(0, 3) != 0);
            step(acc);
            if (acc >= 0) v[acc] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 2) == 0) begin
                    v[i]  = 1'b1;
                    op[i] = 2'($urandom);
                    x[i]  = 4'($urandom);
                    y[i]  = 4'($urandom);
                end
            end
        end

`ifdef BITWISE_ARB_STALL_CNT_EN
        // Stall counter counting and saturation
        v = '0;
        rr = 1'b1;
        reset_mid();
        v = 4'b1111;
        rr = 1'b0;
        step(acc);
        repeat (10) step(acc);
        chk("stall_10", 32'(stall_cnt), 32'd10);
        repeat (65524) step(acc);
        chk("stall_fffe", 32'(stall_cnt), 32'hFFFE);
        repeat (5) step(acc);
        chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
